// File: rtl/input_fm_pingpong_bank.sv
// Double-buffered input feature-map bank: the load side fills one half
// while the conv core reads the other; halves swap on explicit release.
module input_fm_pingpong_bank #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int X  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_tile_reset,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_ena,
    output logic          wr_ready,
    output logic          wr_overflow,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_release
);

    localparam int CAP   = (Tm / X) * Tr * Tc;
    localparam int DEPTH = 2 * CAP;
    localparam int RW    = $clog2(DEPTH);

    localparam logic [AW:0]   CAP_L = (AW + 1)'(CAP);
    localparam logic [RW-1:0] OFS   = RW'(CAP);

    logic          wr_sel;
    logic          rd_sel;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic [AW-1:0] wr_cnt;
    logic [AW:0]   len_q;

    // one-cycle write pipe and the deferred full-flag set it implies
    logic          wp_en;
    logic [RW-1:0] wp_idx;
    logic [DW-1:0] wp_data;
    logic          fs_pend;
    logic          fs_idx;

    logic [DW-1:0] ram [DEPTH];

    logic          wr_acc;
    logic          wr_last;
    logic          rel_acc;
    logic [RW-1:0] wr_idx;
    logic [RW-1:0] rd_idx;

    assign wr_ready = ~full[wr_sel];
    assign rd_valid = full[rd_sel];
    assign wr_acc   = wr_ena & wr_ready;
    assign rel_acc  = rd_release & rd_valid;
    assign wr_last  = ({1'b0, wr_cnt} == len_q - (AW + 1)'(1));
    assign wr_idx   = RW'(wr_cnt) + (wr_sel ? OFS : RW'(0));
    assign rd_idx   = RW'(rd_addr) + (rd_sel ? OFS : RW'(0));

    // Full flags: set one cycle after the last write, cleared on release.
    always_comb begin
        full_nxt = full;
        if (fs_pend) begin
            full_nxt[fs_idx] = 1'b1;
        end
        if (rel_acc) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    // Bank control state, write pipe and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            full        <= 2'b00;
            wr_cnt      <= '0;
            len_q       <= CAP_L;
            wr_overflow <= 1'b0;
            rd_data     <= '0;
            wp_en       <= 1'b0;
            wp_idx      <= '0;
            wp_data     <= '0;
            fs_pend     <= 1'b0;
            fs_idx      <= 1'b0;
        end else if (conv_tile_reset) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            full        <= 2'b00;
            wr_cnt      <= '0;
            len_q       <= (fill_len == '0) ? CAP_L : {1'b0, fill_len};
            wr_overflow <= 1'b0;
            rd_data     <= '0;
            wp_en       <= 1'b0;
            fs_pend     <= 1'b0;
        end else begin
            wp_en   <= wr_acc;
            wp_idx  <= wr_idx;
            wp_data <= wr_data;
            fs_pend <= wr_acc & wr_last;
            fs_idx  <= wr_sel;
            if (wr_acc) begin
                if (wr_last) begin
                    wr_cnt <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    wr_cnt <= wr_cnt + AW'(1);
                end
            end
            if (wr_ena & ~wr_ready) begin
                wr_overflow <= 1'b1;
            end
            full <= full_nxt;
            if (rel_acc) begin
                rd_sel <= ~rd_sel;
            end
            rd_data <= ram[rd_idx];
        end
    end

    // RAM write port, fed from the registered write pipe.
    always_ff @(posedge clk) begin
        if (wp_en) begin
            ram[wp_idx] <= wp_data;
        end
    end

endmodule

// File: tb/tb_input_fm_pingpong_bank.sv
// Bench for input_fm_pingpong_bank: scoreboard of per-cycle flag and
// read-data expectations from a half-level model of the ping-pong bank.
module tb_input_fm_pingpong_bank;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int CAP = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          conv_tile_reset;
    logic [AW-1:0] fill_len;
    logic [DW-1:0] wr_data;
    logic          wr_ena;
    logic          wr_ready;
    logic          wr_overflow;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_release;

    input_fm_pingpong_bank dut (
        .clk(clk),
        .rst(rst),
        .conv_tile_reset(conv_tile_reset),
        .fill_len(fill_len),
        .wr_data(wr_data),
        .wr_ena(wr_ena),
        .wr_ready(wr_ready),
        .wr_overflow(wr_overflow),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_release(rd_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          vld;
        bit          ovf;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // model: contents per half, fill state, and cycle a half becomes readable
    logic [31:0] mem [2][CAP];
    bit          m_filled [2];
    int          m_avail [2];
    int          m_wh, m_rh, m_cnt, m_len;
    bit          m_ovf;
    int          cyc = 0;
    bit          nxt_chk;
    logic [31:0] nxt_data;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int len);
        m_filled[0] = 0;
        m_filled[1] = 0;
        m_wh = 0;
        m_rh = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_len = len;
    endtask

    // one clock cycle: record expectations, drive inputs, advance the model
    task automatic step(input bit ena, input logic [31:0] d, input int addr,
                        input bit rel, input bit ctr, input int flen);
        exp_t e;
        bit   vld;
        bit   rdy;
        int   rrh;
        @(posedge clk);
        #1;
        rdy = !m_filled[m_wh];
        vld = m_filled[m_rh] && (cyc >= m_avail[m_rh]);
        e.rdy = rdy;
        e.vld = vld;
        e.ovf = m_ovf;
        e.chk = nxt_chk;
        e.data = nxt_data;
        q.push_back(e);
        wr_ena = ena;
        wr_data = d;
        rd_addr = AW'(addr);
        rd_release = rel;
        conv_tile_reset = ctr;
        fill_len = AW'(flen);
        if (ctr) begin
            model_clear((flen == 0) ? CAP : flen);
            nxt_chk = 1;
            nxt_data = '0;
        end else begin
            rrh = m_rh;
            if (ena) begin
                if (rdy) begin
                    mem[m_wh][m_cnt] = d;
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_cnt = 0;
                        m_filled[m_wh] = 1;
                        m_avail[m_wh] = cyc + 2;
                        m_wh ^= 1;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            if (rel && vld) begin
                m_filled[m_rh] = 0;
                m_rh ^= 1;
            end
            nxt_chk = vld && (addr < m_len);
            nxt_data = nxt_chk ? mem[rrh][addr] : '0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] d);
        step(1, d, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, '0, a, 0, 0, 0);
    endtask

    // monitor: compare DUT outputs against the queued expectations
    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            check("wr_ready", 32'(wr_ready), 32'(me.rdy));
            check("rd_valid", 32'(rd_valid), 32'(me.vld));
            check("wr_overflow", 32'(wr_overflow), 32'(me.ovf));
            if (me.chk) check("rd_data", rd_data, me.data);
        end
    end

    initial begin
        rst = 1'b1;
        conv_tile_reset = 1'b0;
        fill_len = '0;
        wr_data = '0;
        wr_ena = 1'b0;
        rd_addr = '0;
        rd_release = 1'b0;
        m_avail[0] = 0;
        m_avail[1] = 0;
        model_clear(CAP);
        nxt_chk = 0;
        nxt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // release with nothing readable is ignored
        step(0, '0, 0, 1, 0, 0);
        // basic fill of 4 and read back
        step(0, '0, 0, 0, 1, 4);
        for (int i = 0; i < 4; i++) wr(32'hA000_0000 + 32'(i));
        idle(2);
        for (int i = 0; i < 4; i++) rd(i);
        // second half full too, overflow, release, read second half
        for (int i = 0; i < 4; i++) wr(32'hB000_0000 + 32'(i));
        idle(2);
        wr(32'hDEAD_BEEF);
        step(0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) rd(i);
        // last write of half1 coincides with release of half0
        step(0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) wr(32'hC000_0000 + 32'(i));
        idle(2);
        for (int i = 0; i < 3; i++) wr(32'hD000_0000 + 32'(i));
        step(1, 32'hD000_0003, 0, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) rd(i);

        // async reset mid-fill with overflow flag set
        step(0, '0, 0, 0, 1, 4);
        for (int i = 0; i < 9; i++) wr(32'hE000_0000 + 32'(i));
        step(0, '0, 0, 1, 0, 0);
        wr(32'hF000_0000);
        wr(32'hF000_0001);
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        rd_release = 1'b0;
        rst = 1'b1;
        #1;
        check("rst wr_ready", 32'(wr_ready), 32'd1);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst wr_overflow", 32'(wr_overflow), 32'd0);
        check("rst rd_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear(CAP);
        nxt_chk = 0;

        // randomized traffic with small tile lengths
        step(0, '0, 0, 0, 1, 3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(0, '0, 0, 0, 1, $urandom_range(1, 8));
            end else begin
                step(($urandom_range(0, 3) != 0), $urandom,
                     $urandom_range(0, m_len + 1),
                     ($urandom_range(0, 5) == 0), 0, 0);
            end
        end

        // fill_len 0 means full capacity
        step(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < CAP - 1; i++) wr(32'h5000_0000 + 32'(i));
        idle(3);
        wr(32'h5000_0FFF);
        idle(2);
        rd(0);
        rd(CAP - 1);
        rd(2048);
        idle(2);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
